// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, FSM states, owner ids.
package dm_pkg;

   // Access size codes carried on *_size
   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   localparam logic [1:0] SIZE_X = 2'b11;

   // Arbiter sequencing: one access takes IDLE -> ACCESS -> RESP
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } state_t;

   // Which requester owns the transaction in flight
   typedef enum logic {
      OWN_C = 1'b0,
      OWN_D = 1'b1
   } owner_t;

endpackage

// File: rtl/dm_be_gen.sv
// Byte-enable and alignment check for a single access.
// On any error the enables are forced to zero so nothing downstream can write.
module dm_be_gen
   import dm_pkg::*;
(
   input  logic [1:0] size,
   input  logic [1:0] addr_lo,
   output logic [3:0] be,
   output logic       err
);

   // Decode size and low address bits into lane enables, flag misalignment
   always_comb begin
      be  = 4'b0000;
      err = 1'b0;
      case (size)
         SIZE_B: begin
            be = 4'b0001 << addr_lo;
         end
         SIZE_H: begin
            if (addr_lo[0]) begin
               err = 1'b1;
            end else begin
               be = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
         end
         SIZE_W: begin
            if (addr_lo != 2'b00) begin
               err = 1'b1;
            end else begin
               be = 4'b1111;
            end
         end
         SIZE_X: begin
            err = 1'b1;
         end
         default: begin
            err = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port front end for the single-port data memory.
// Port C (CPU) has fixed priority; port D (DMA/debug) is protected from
// starvation by a wait counter that hands it the next slot after MAX_WAIT
// lost arbitration rounds. Each access is IDLE -> ACCESS -> RESP.
module dm_arbiter
   import dm_pkg::*;
#(
   parameter int MAX_WAIT = 8,
   parameter int WAIT_W   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   // port C
   input  logic        c_req,
   input  logic        c_we,
   input  logic [1:0]  c_size,
   input  logic        c_sign,
   input  logic [11:0] c_addr,
   input  logic [31:0] c_wdata,
   output logic        c_ack,
   output logic        c_err,
   output logic [31:0] c_rdata,
   // port D
   input  logic        d_req,
   input  logic        d_we,
   input  logic [1:0]  d_size,
   input  logic        d_sign,
   input  logic [11:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic        d_err,
   output logic [31:0] d_rdata,
   // memory side
   output logic [9:0]  dm_addr,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_din,
   output logic        dm_we,
   output logic        dm_ldsign,
   input  logic [31:0] dm_dout
);

   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

   state_t              state_reg;
   state_t              state_next;
   logic [WAIT_W-1:0]   wait_cnt_reg;
   logic [WAIT_W-1:0]   wait_cnt_next;

   // Fields of the transaction in flight, captured when it is granted
   owner_t              own_reg;
   logic                we_reg;
   logic [1:0]          size_reg;
   logic                sign_reg;
   logic [11:0]         addr_reg;
   logic [31:0]         din_reg;

   logic                grant_en;
   logic                grant_d;
   logic                in_access;
   logic [3:0]          be;
   logic                be_err;

   dm_be_gen u_be_gen (
      .size    (size_reg),
      .addr_lo (addr_reg[1:0]),
      .be      (be),
      .err     (be_err)
   );

   assign in_access = (state_reg == ST_ACCESS);

   // State and starvation counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         wait_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

   // Arbitration, next state, starvation counter update and memory strobes
   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      grant_en      = 1'b0;
      grant_d       = 1'b0;
      dm_we         = 1'b0;
      dm_be         = 4'b0000;
      case (state_reg)
         ST_IDLE: begin
            grant_en = c_req | d_req;
            // D wins alone, or against C once it has waited long enough
            grant_d  = d_req & (~c_req | (wait_cnt_reg == WAIT_LIMIT));
            if (grant_en) begin
               state_next = ST_ACCESS;
            end
            if (!d_req || grant_d) begin
               wait_cnt_next = '0;
            end else if (wait_cnt_reg != WAIT_LIMIT) begin
               wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
            end
         end
         ST_ACCESS: begin
            // be is already zero on an alignment/size error
            dm_be      = be;
            dm_we      = we_reg & ~be_err & rst_n;
            state_next = ST_RESP;
            if (!d_req) begin
               wait_cnt_next = '0;
            end
         end
         ST_RESP: begin
            state_next = ST_IDLE;
            if (!d_req) begin
               wait_cnt_next = '0;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Capture the winning requester's fields at grant time
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         own_reg  <= OWN_C;
         we_reg   <= 1'b0;
         size_reg <= 2'b00;
         sign_reg <= 1'b0;
         addr_reg <= '0;
         din_reg  <= '0;
      end else if (grant_en) begin
         own_reg  <= grant_d ? OWN_D : OWN_C;
         we_reg   <= grant_d ? d_we    : c_we;
         size_reg <= grant_d ? d_size  : c_size;
         sign_reg <= grant_d ? d_sign  : c_sign;
         addr_reg <= grant_d ? d_addr  : c_addr;
         din_reg  <= grant_d ? d_wdata : c_wdata;
      end
   end

   assign dm_addr   = addr_reg[11:2];
   assign dm_din    = din_reg;
   assign dm_ldsign = sign_reg;

   // Per-port response registers: ack/err/rdata become visible in RESP
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : gen_port
         localparam owner_t PORT_OWN = (gi == 0) ? OWN_C : OWN_D;
         logic        ack_reg;
         logic        err_reg;
         logic [31:0] rdata_reg;

         // Load the owner's response at the end of ACCESS; ack lasts one cycle
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               ack_reg   <= 1'b0;
               err_reg   <= 1'b0;
               rdata_reg <= '0;
            end else if (in_access && own_reg == PORT_OWN) begin
               ack_reg   <= 1'b1;
               err_reg   <= be_err;
               rdata_reg <= (we_reg || be_err) ? 32'h0 : dm_dout;
            end else begin
               ack_reg   <= 1'b0;
               err_reg   <= 1'b0;
            end
         end
      end
   endgenerate

   assign c_ack   = gen_port[0].ack_reg;
   assign c_err   = gen_port[0].err_reg;
   assign c_rdata = gen_port[0].rdata_reg;
   assign d_ack   = gen_port[1].ack_reg;
   assign d_err   = gen_port[1].err_reg;
   assign d_rdata = gen_port[1].rdata_reg;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural data memory attached.
module tb_dm_arbiter;

   logic        clk;
   logic        rst_n;
   logic        c_req, c_we, c_sign;
   logic [1:0]  c_size;
   logic [11:0] c_addr;
   logic [31:0] c_wdata;
   logic        c_ack, c_err;
   logic [31:0] c_rdata;
   logic        d_req, d_we, d_sign;
   logic [1:0]  d_size;
   logic [11:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack, d_err;
   logic [31:0] d_rdata;
   logic [9:0]  dm_addr;
   logic [3:0]  dm_be;
   logic [31:0] dm_din;
   logic        dm_we;
   logic        dm_ldsign;
   logic [31:0] dm_dout;

   int checks = 0;
   int errors = 0;

   dm_arbiter #(.MAX_WAIT(8), .WAIT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_sign(c_sign),
      .c_addr(c_addr), .c_wdata(c_wdata),
      .c_ack(c_ack), .c_err(c_err), .c_rdata(c_rdata),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_sign(d_sign),
      .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
      .dm_addr(dm_addr), .dm_be(dm_be), .dm_din(dm_din), .dm_we(dm_we),
      .dm_ldsign(dm_ldsign), .dm_dout(dm_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural dm: right-aligned data is placed on the lowest enabled lane
   logic [31:0] mem [0:1023];

   function automatic int low_lane(input logic [3:0] be);
      int lo = 0;
      for (int i = 3; i >= 0; i--) if (be[i]) lo = i;
      return lo;
   endfunction

   always @(posedge clk) begin
      if (dm_we) begin
         for (int i = 0; i < 4; i++) begin
            if (dm_be[i]) mem[dm_addr][8*i +: 8] <= (dm_din << (8 * low_lane(dm_be))) >> (8 * i);
         end
      end
   end

   always_comb begin
      logic [31:0] rd;
      rd = mem[dm_addr] >> (8 * low_lane(dm_be));
      case (dm_be)
         4'b0001, 4'b0010, 4'b0100, 4'b1000:
            dm_dout = dm_ldsign ? {{24{rd[7]}}, rd[7:0]} : {24'h0, rd[7:0]};
         4'b0011, 4'b1100:
            dm_dout = dm_ldsign ? {{16{rd[15]}}, rd[15:0]} : {16'h0, rd[15:0]};
         default:
            dm_dout = rd;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Issue one transaction from idle; returns response, latency and what the memory saw
   task automatic run_txn(input bit on_d, input logic we, input logic [1:0] size,
                          input logic sign, input logic [11:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output logic [3:0] be_seen, output logic we_seen);
      if (on_d) begin
         d_req = 1'b1; d_we = we; d_size = size; d_sign = sign; d_addr = addr; d_wdata = wdata;
      end else begin
         c_req = 1'b1; c_we = we; c_size = size; c_sign = sign; c_addr = addr; c_wdata = wdata;
      end
      lat = -1; rdata = '0; err = 1'b0; be_seen = 4'b0000; we_seen = 1'b0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(posedge clk); #1;
         we_seen = we_seen | dm_we;
         if (dm_be != 4'b0000) be_seen = dm_be;
         if (on_d ? d_ack : c_ack) begin
            lat   = cyc;
            rdata = on_d ? d_rdata : c_rdata;
            err   = on_d ? d_err : c_err;
            break;
         end
      end
      c_req = 1'b0;
      d_req = 1'b0;
      @(posedge clk); #1;
      check("ack_pulse", 32'(on_d ? d_ack : c_ack), 32'h0);
      $display("txn port=%s we=%0d size=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
               on_d ? "D" : "C", we, size, addr, wdata, rdata, err, lat);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_c_ack"},   32'(c_ack),     32'h0);
      check({tag, "_d_ack"},   32'(d_ack),     32'h0);
      check({tag, "_c_err"},   32'(c_err),     32'h0);
      check({tag, "_d_err"},   32'(d_err),     32'h0);
      check({tag, "_c_rdata"}, c_rdata,        32'h0);
      check({tag, "_d_rdata"}, d_rdata,        32'h0);
      check({tag, "_dm_we"},   32'(dm_we),     32'h0);
      check({tag, "_dm_be"},   32'(dm_be),     32'h0);
      check({tag, "_dm_addr"}, 32'(dm_addr),   32'h0);
      check({tag, "_dm_din"},  dm_din,         32'h0);
      check({tag, "_dm_sign"}, 32'(dm_ldsign), 32'h0);
   endtask

   logic [31:0] rdata;
   logic        err;
   int          lat;
   logic [3:0]  be_seen;
   logic        we_seen;
   int          c_cnt, d_cnt, c_before_d;
   logic        both_ack;

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      rst_n = 1'b0;
      c_req = 0; c_we = 0; c_size = 0; c_sign = 0; c_addr = 0; c_wdata = 0;
      d_req = 0; d_we = 0; d_size = 0; d_sign = 0; d_addr = 0; d_wdata = 0;
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: word store then signed byte load from the top lane
      run_txn(0, 1, 2'b10, 0, 12'h010, 32'hDEADBEEF, rdata, err, lat, be_seen, we_seen);
      check("sw_lat", 32'(lat), 32'd2);
      check("sw_err", 32'(err), 32'h0);
      check("sw_rdata", rdata, 32'h0);
      check("sw_be", 32'(be_seen), 32'hF);
      check("sw_we", 32'(we_seen), 32'h1);
      run_txn(0, 0, 2'b00, 1, 12'h013, 32'h0, rdata, err, lat, be_seen, we_seen);
      check("lb_lat", 32'(lat), 32'd2);
      check("lb_rdata", rdata, 32'hFFFFFFDE);

      // 2: upper-half store, unsigned and signed half loads
      run_txn(0, 1, 2'b01, 0, 12'h022, 32'h00008001, rdata, err, lat, be_seen, we_seen);
      check("sh_be", 32'(be_seen), 32'hC);
      run_txn(0, 0, 2'b01, 0, 12'h022, 32'h0, rdata, err, lat, be_seen, we_seen);
      check("lhu_rdata", rdata, 32'h00008001);
      run_txn(0, 0, 2'b01, 1, 12'h022, 32'h0, rdata, err, lat, be_seen, we_seen);
      check("lh_rdata", rdata, 32'hFFFF8001);

      // 3: misaligned word load and illegal-size store on D
      run_txn(1, 0, 2'b10, 0, 12'h011, 32'h0, rdata, err, lat, be_seen, we_seen);
      check("mis_lat", 32'(lat), 32'd2);
      check("mis_err", 32'(err), 32'h1);
      check("mis_rdata", rdata, 32'h0);
      check("mis_we", 32'(we_seen), 32'h0);
      run_txn(1, 1, 2'b11, 0, 12'h000, 32'hFFFFFFFF, rdata, err, lat, be_seen, we_seen);
      check("ill_err", 32'(err), 32'h1);
      check("ill_we", 32'(we_seen), 32'h0);
      check("ill_be", 32'(be_seen), 32'h0);
      run_txn(0, 0, 2'b10, 0, 12'h000, 32'h0, rdata, err, lat, be_seen, we_seen);
      check("ill_nowrite", rdata, 32'h0);

      // 4/5: both ports request back to back; D must get every ninth slot
      c_req = 1; c_we = 0; c_size = 2'b10; c_sign = 0; c_addr = 12'h010; c_wdata = 0;
      d_req = 1; d_we = 1; d_size = 2'b10; d_sign = 0; d_addr = 12'h040; d_wdata = 32'h12345678;
      c_cnt = 0; d_cnt = 0; c_before_d = -1; both_ack = 1'b0;
      for (int cyc = 0; cyc < 108; cyc++) begin
         @(posedge clk); #1;
         if (c_ack && d_ack) both_ack = 1'b1;
         if (c_ack) begin
            c_cnt++;
            if (c_rdata !== 32'hDEADBEEF) check("arb_c_rdata", c_rdata, 32'hDEADBEEF);
         end
         if (d_ack) begin
            if (d_cnt == 0) c_before_d = c_cnt;
            d_cnt++;
            $display("arb D ack after %0d C acks (cycle %0d) err=%0d", c_cnt, cyc, d_err);
         end
      end
      c_req = 0;
      d_req = 0;
      @(posedge clk); #1;
      check("arb_first_d", 32'(c_before_d), 32'd8);
      check("arb_d_cnt", 32'(d_cnt), 32'd4);
      check("arb_c_cnt", 32'(c_cnt), 32'd32);
      check("arb_both", 32'(both_ack), 32'h0);
      run_txn(0, 0, 2'b10, 0, 12'h040, 32'h0, rdata, err, lat, be_seen, we_seen);
      check("d_store_read", rdata, 32'h12345678);

      // byte store into an existing word
      run_txn(0, 1, 2'b00, 0, 12'h011, 32'h0000005A, rdata, err, lat, be_seen, we_seen);
      check("sb_be", 32'(be_seen), 32'h2);
      run_txn(0, 0, 2'b00, 0, 12'h011, 32'h0, rdata, err, lat, be_seen, we_seen);
      check("lbu_rdata", rdata, 32'h0000005A);
      run_txn(0, 0, 2'b10, 0, 12'h010, 32'h0, rdata, err, lat, be_seen, we_seen);
      check("sb_word", rdata, 32'hDEAD5AEF);

      // 6: reset in the middle of a store's ACCESS cycle
      run_txn(0, 1, 2'b10, 0, 12'h080, 32'h0000AAAA, rdata, err, lat, be_seen, we_seen);
      c_req = 1; c_we = 1; c_size = 2'b10; c_sign = 0; c_addr = 12'h080; c_wdata = 32'hFFFFFFFF;
      @(posedge clk); #1;
      check("rst_we_access", 32'(dm_we), 32'h1);
      rst_n = 1'b0;
      c_req = 1'b0;
      #1;
      check("rst_we_gated", 32'(dm_we), 32'h0);
      @(posedge clk); #1;
      check_zero_outputs("midrst");
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_no_ack", 32'(c_ack), 32'h0);
      run_txn(0, 0, 2'b10, 0, 12'h080, 32'h0, rdata, err, lat, be_seen, we_seen);
      check("rst_prior", rdata, 32'h0000AAAA);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
